// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and baud-rate constants.
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_e;

  localparam int unsigned BAUD_4800  = 4800;
  localparam int unsigned BAUD_9600  = 9600;
  localparam int unsigned BAUD_19200 = 19200;
  localparam int unsigned BAUD_38400 = 38400;
  localparam int unsigned BAUD_57600 = 57600;

  // Rounded clock divisor used by the baud generator for a given rate.
  function automatic int unsigned baud_divisor(input int unsigned clk_hz,
                                               input int unsigned baud);
    return (clk_hz + (baud / 2)) / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO with wrap-bit pointers and async reset.
`default_nettype none

module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign rdata = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[ADDR_W-1:0]] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: FIFO-buffered UART transmitter paced by an external baud tick.
`default_nettype none

module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              baud_tick_i,
  input  logic              parity_en_i,
  input  logic              parity_odd_i,
  input  logic              stop2_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;

  uart_tx_state_e    state, next_state;
  logic [DATA_W-1:0] shift, next_shift;
  logic [CNT_W-1:0]  bit_cnt, next_bit_cnt;
  logic              stop_cnt, next_stop_cnt;
  logic              par_en, next_par_en;
  logic              par_bit, next_par_bit;
  logic              stop2, next_stop2;
  logic              tx_q, next_tx;
  logic              busy_q;
  logic              done_q, next_done;
  logic              start_frame;

  uart_tx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (tx_valid_i),
    .wdata (tx_data_i),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tx_ready_o   = !fifo_full;
  assign tx_o         = tx_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      stop2    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= next_state;
      shift    <= next_shift;
      bit_cnt  <= next_bit_cnt;
      stop_cnt <= next_stop_cnt;
      par_en   <= next_par_en;
      par_bit  <= next_par_bit;
      stop2    <= next_stop2;
      tx_q     <= next_tx;
      busy_q   <= (next_state != IDLE);
      done_q   <= next_done;
    end
  end

  always_comb begin
    next_state    = state;
    next_shift    = shift;
    next_bit_cnt  = bit_cnt;
    next_stop_cnt = stop_cnt;
    next_par_en   = par_en;
    next_par_bit  = par_bit;
    next_stop2    = stop2;
    next_tx       = tx_q;
    next_done     = 1'b0;
    fifo_pop      = 1'b0;
    start_frame   = 1'b0;

    if (baud_tick_i) begin
      unique case (state)
        IDLE: begin
          if (!fifo_empty) start_frame = 1'b1;
        end
        START: begin
          next_tx      = shift[0];
          next_bit_cnt = '0;
          next_state   = DATA;
        end
        DATA: begin
          if (bit_cnt == LAST_BIT) begin
            next_stop_cnt = 1'b0;
            if (par_en) begin
              next_tx    = par_bit;
              next_state = PARITY;
            end else begin
              next_tx    = 1'b1;
              next_state = STOP;
            end
          end else begin
            next_shift   = shift >> 1;
            next_tx      = next_shift[0];
            next_bit_cnt = bit_cnt + 1'b1;
          end
        end
        PARITY: begin
          next_tx       = 1'b1;
          next_stop_cnt = 1'b0;
          next_state    = STOP;
        end
        STOP: begin
          if (stop_cnt == stop2) begin
            next_done = 1'b1;
            if (!fifo_empty) begin
              start_frame = 1'b1;
            end else begin
              next_tx    = 1'b1;
              next_state = IDLE;
            end
          end else begin
            next_stop_cnt = 1'b1;
          end
        end
        default: begin
          next_tx    = 1'b1;
          next_state = IDLE;
        end
      endcase
    end

    // Frame configuration and parity are captured together with the byte.
    if (start_frame) begin
      fifo_pop     = 1'b1;
      next_shift   = fifo_rdata;
      next_par_en  = parity_en_i;
      next_par_bit = (^fifo_rdata) ^ parity_odd_i;
      next_stop2   = stop2_i;
      next_tx      = 1'b0;
      next_state   = START;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed and randomized checks against a frame-level line model.
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_serializer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              baud_tick = 1'b0;
  logic              parity_en = 1'b0;
  logic              parity_odd = 1'b0;
  logic              stop2 = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_valid = 1'b0;
  logic              tx_ready;
  logic              tx;
  logic              busy;
  logic              frame_done;

  uart_tx_serializer #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .baud_tick_i  (baud_tick),
    .parity_en_i  (parity_en),
    .parity_odd_i (parity_odd),
    .stop2_i      (stop2),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
    .tx_o         (tx),
    .busy_o       (busy),
    .frame_done_o (frame_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Baud strobe source: one pulse every tick_period clocks, optionally with random gaps.
  int tick_period = 4;
  bit tick_en     = 1'b1;
  bit tick_gaps   = 1'b0;
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (tick_en && cnt >= tick_period - 1 && !(tick_gaps && $urandom_range(0, 2) == 0)) begin
        baud_tick = 1'b1;
        cnt = 0;
      end else begin
        baud_tick = 1'b0;
        if (tick_en && cnt < tick_period - 1) cnt++;
      end
    end
  end

  // Reference model: list of accepted bytes plus the bit pattern of the frame on the line.
  byte unsigned mq[$];
  bit           m_active = 1'b0;
  logic         m_bits[12];
  int           m_nbits = 0;
  int           m_idx   = 0;

  function automatic void build_frame(input byte unsigned d, input bit pe, input bit po, input bit s2);
    int n;
    m_bits[0] = 1'b0;
    for (int i = 0; i < DATA_W; i++) m_bits[1 + i] = d[i];
    n = 1 + DATA_W;
    if (pe) begin
      // Even parity makes the total count of ones even; odd makes it odd.
      m_bits[n] = (($countones(d) % 2) == 1) ? !po : po;
      n++;
    end
    m_bits[n] = 1'b1;
    n++;
    if (s2) begin
      m_bits[n] = 1'b1;
      n++;
    end
    m_nbits  = n;
    m_idx    = 0;
    m_active = 1'b1;
  endfunction

  initial begin
    bit s_tick, s_valid, s_pe, s_po, s_s2, pushed, exp_done;
    byte unsigned s_data;
    forever begin
      @(posedge clk);
      s_tick = baud_tick; s_valid = tx_valid; s_data = tx_data;
      s_pe = parity_en; s_po = parity_odd; s_s2 = stop2;
      exp_done = 1'b0;
      if (rst) begin
        mq.delete();
        m_active = 1'b0;
      end else begin
        pushed = s_valid && (mq.size() < DEPTH);
        if (s_tick) begin
          if (m_active) begin
            m_idx++;
            if (m_idx == m_nbits) begin
              exp_done = 1'b1;
              m_active = 1'b0;
            end
          end
          if (!m_active && mq.size() > 0) build_frame(mq.pop_front(), s_pe, s_po, s_s2);
        end
        if (pushed) mq.push_back(s_data);
      end
      #1;
      check_eq("line", 32'(tx), m_active ? 32'(m_bits[m_idx]) : 32'd1);
      check_eq("busy", 32'(busy), 32'(m_active));
      check_eq("frame_done", 32'(frame_done), 32'(exp_done));
      check_eq("ready", 32'(tx_ready), 32'(mq.size() < DEPTH));
    end
  end

  task automatic wait_tick_edge();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (baud_tick) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    if (!ok) check_eq("tick_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) wait_tick_edge();
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #2;
      if (!m_active && mq.size() == 0 && !tx_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("idle_timeout", 32'(ok), 32'd1);
  endtask

  task automatic push_byte(input byte unsigned d);
    int n = 0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    while (!tx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check_eq("push_timeout", 32'(tx_ready), 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("rst_line", 32'(tx), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ready", 32'(tx_ready), 32'd1);
    check_eq("rst_done", 32'(frame_done), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic a5_seq [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset asserted while a frame is on the line.
    push_byte(8'h3C);
    wait_ticks(3);
    check_eq("pre_rst_line", 32'(tx), 32'd0);
    async_reset();
    wait_ticks(12);

    // 0xA5, no parity, one stop bit.
    push_byte(8'hA5);
    for (int i = 0; i < 10; i++) begin
      wait_tick_edge();
      check_eq("a5_bit", 32'(tx), 32'(a5_seq[i]));
    end
    wait_tick_edge();
    check_eq("a5_done", 32'(frame_done), 32'd1);
    @(posedge clk);
    #1;
    check_eq("a5_done_off", 32'(frame_done), 32'd0);
    check_eq("a5_busy_off", 32'(busy), 32'd0);
    wait_idle();

    // Parity and two stop bits on 0x07.
    parity_en = 1'b1; parity_odd = 1'b0;
    push_byte(8'h07);
    wait_ticks(10);
    check_eq("par_even", 32'(tx), 32'd1);
    wait_idle();
    parity_odd = 1'b1;
    push_byte(8'h07);
    wait_ticks(10);
    check_eq("par_odd", 32'(tx), 32'd0);
    wait_idle();
    parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b1;
    push_byte(8'h07);
    wait_ticks(10);
    check_eq("stop2_first", 32'(tx), 32'd1);
    wait_tick_edge();
    check_eq("stop2_second", 32'(tx), 32'd1);
    check_eq("stop2_not_done", 32'(frame_done), 32'd0);
    wait_tick_edge();
    check_eq("stop2_done", 32'(frame_done), 32'd1);
    wait_idle();
    stop2 = 1'b0;

    // Fill the FIFO with ticks held off, then drain back to back.
    @(negedge clk);
    tick_en = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(byte'(8'h11 + i));
    @(negedge clk);
    check_eq("full_ready", 32'(tx_ready), 32'd0);
    tick_en = 1'b1;
    push_byte(8'h15);
    wait_idle();

    // Config change mid-frame only affects the following frame.
    push_byte(8'h5A);
    wait_ticks(4);
    parity_en = 1'b1;
    push_byte(8'h5B);
    wait_idle();
    parity_en = 1'b0;

    // Reset during DATA with bytes queued, then ticks with random gaps.
    @(negedge clk);
    tick_en = 1'b0;
    push_byte(8'hFF);
    push_byte(8'h12);
    push_byte(8'h34);
    @(negedge clk);
    tick_en = 1'b1;
    wait_ticks(4);
    async_reset();
    tick_gaps = 1'b1;
    wait_ticks(30);
    check_eq("post_rst_busy", 32'(busy), 32'd0);

    // Randomized traffic, configuration and tick spacing.
    for (int blk = 0; blk < 6; blk++) begin
      @(negedge clk);
      tick_period = int'($urandom_range(1, 6));
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        tx_valid = ($urandom_range(0, 3) == 0);
        tx_data  = 8'($urandom);
        if ($urandom_range(0, 15) == 0) parity_en  = 1'($urandom);
        if ($urandom_range(0, 15) == 0) parity_odd = 1'($urandom);
        if ($urandom_range(0, 15) == 0) stop2      = 1'($urandom);
      end
      @(negedge clk);
      tx_valid = 1'b0;
    end
    wait_idle();
    repeat (5) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
